hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 142 ++++++++++++++
 tb/tb_hazard_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// hazard_controller: operand forwarding, load-use/branch hazards and
// data-memory stall control with a sticky timeout error.
// Rev 1.0
// ============================================================================
module hazard_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  input  logic             ClearCount,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [7:0]       c_waitLast = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cntMax   = '1;

  state_t           r_state;
  state_t           w_stateNext;
  logic [7:0]       r_waitCnt;
  logic [7:0]       w_waitCntNext;
  logic [CNT_W-1:0] r_stallCount;
  logic             w_memStall;
  logic             w_lwStall;
  logic             w_stallFD;

  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic [4:0] rdM,
    input logic       wrM,
    input logic [4:0] rdW,
    input logic       wrW
  );
    if (rs != 5'd0 && rs == rdM && wrM)      return 2'b10;
    else if (rs != 5'd0 && rs == rdW && wrW) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign w_lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_stallFD = w_lwStall | w_memStall;

  always_comb begin
    w_stateNext   = r_state;
    w_waitCntNext = r_waitCnt;
    w_memStall    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_memStall = MemAccessM & ~MemReadyM;
        if (w_memStall) begin
          w_stateNext   = WAIT;
          w_waitCntNext = 8'd1;
        end
      end
      WAIT: begin
        w_memStall = ~MemReadyM;
        if (MemReadyM) begin
          w_stateNext   = IDLE;
          w_waitCntNext = 8'd0;
        end else if (r_waitCnt == c_waitLast) begin
          w_stateNext = ERROR;
        end else begin
          w_waitCntNext = r_waitCnt + 8'd1;
        end
      end
      ERROR: begin
        w_memStall = 1'b1;
      end
      default: begin
        w_stateNext   = IDLE;
        w_waitCntNext = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_waitCnt <= 8'd0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitCntNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCount <= '0;
    end else if (ClearCount) begin
      r_stallCount <= '0;
    end else if (w_stallFD && r_stallCount != c_cntMax) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign ForwardAE  = rst ? fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
  assign ForwardBE  = rst ? fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
  assign StallF     = rst & w_stallFD;
  assign StallD     = rst & w_stallFD;
  assign StallE     = rst & w_memStall;
  assign StallM     = rst & w_memStall;
  assign FlushW     = rst & w_memStall;
  // A memory stall holds the branch in Execute, so its flushes must wait.
  assign FlushD     = rst & PCSrcE & ~w_memStall;
  assign FlushE     = rst & (w_lwStall | PCSrcE) & ~w_memStall;
  assign MemError   = (r_state == ERROR);
  assign StallCount = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// Bench for hazard_controller: random and directed stimulus, expected
// responses queued from a behavioural model and checked by a monitor.
module tb_hazard_controller;

  localparam int TO      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          RegWriteM, RegWriteW, PCSrcE, MemAccessM, MemReadyM, ClearCount;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemError;
  logic [CW-1:0] StallCount;

  hazard_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .ClearCount(ClearCount),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemError(MemError), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0] resultSrcE;
    logic       regWriteM, regWriteW, pcSrcE, memAccessM, memReadyM, clearCount;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        sF, sD, sE, sM, fD, fE, fW, mErr;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: sticky error, consecutive memory-stall cycles, stall counter.
  bit   mErr = 1'b0;
  int   mRun = 0;
  int   mCnt = 0;

  function automatic logic [1:0] fwdRef(input logic [4:0] rs, input stim_t s);
    if (rs != 0 && rs == s.rdM && s.regWriteM) return 2'd2;
    if (rs != 0 && rs == s.rdW && s.regWriteW) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("ForwardAE",  32'(ForwardAE),  32'(e.fa));
      chk("ForwardBE",  32'(ForwardBE),  32'(e.fb));
      chk("StallF",     32'(StallF),     32'(e.sF));
      chk("StallD",     32'(StallD),     32'(e.sD));
      chk("StallE",     32'(StallE),     32'(e.sE));
      chk("StallM",     32'(StallM),     32'(e.sM));
      chk("FlushD",     32'(FlushD),     32'(e.fD));
      chk("FlushE",     32'(FlushE),     32'(e.fE));
      chk("FlushW",     32'(FlushW),     32'(e.fW));
      chk("MemError",   32'(MemError),   32'(e.mErr));
      chk("StallCount", 32'(StallCount), e.cnt);
    end
  end

  // Called just after a rising edge; drives one cycle and consumes its edge.
  task automatic applyCycle(input stim_t s, input logic rv);
    exp_t e;
    bit   ms, lw;
    rst = rv;
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW; ResultSrcE = s.resultSrcE;
    RegWriteM = s.regWriteM; RegWriteW = s.regWriteW; PCSrcE = s.pcSrcE;
    MemAccessM = s.memAccessM; MemReadyM = s.memReadyM; ClearCount = s.clearCount;
    e  = '0;
    ms = 1'b0;
    lw = 1'b0;
    if (!rv) begin
      mErr = 1'b0; mRun = 0; mCnt = 0;
    end else begin
      ms = mErr || (!s.memReadyM && (mRun > 0 || s.memAccessM));
      lw = (s.resultSrcE == 2'd1) && (s.rdE != 0) &&
           (s.rdE == s.rs1D || s.rdE == s.rs2D);
      e.fa   = fwdRef(s.rs1E, s);
      e.fb   = fwdRef(s.rs2E, s);
      e.sF   = lw | ms;
      e.sD   = lw | ms;
      e.sE   = ms;
      e.sM   = ms;
      e.fW   = ms;
      e.fD   = s.pcSrcE && !ms;
      e.fE   = (lw || s.pcSrcE) && !ms;
      e.mErr = mErr;
      e.cnt  = 32'(mCnt);
    end
    expQ.push_back(e);
    @(posedge clk);
    if (rv) begin
      if (s.clearCount)                  mCnt = 0;
      else if ((lw || ms) && mCnt < CNT_MAX) mCnt = mCnt + 1;
      if (!mErr) begin
        if (ms) begin
          mRun = mRun + 1;
          if (mRun >= TO) mErr = 1'b1;
        end else begin
          mRun = 0;
        end
      end
    end
    #1;
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    s.memReadyM = 1'b1;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rs1D       = 5'($urandom_range(0, 3));
    s.rs2D       = 5'($urandom_range(0, 3));
    s.rs1E       = 5'($urandom_range(0, 3));
    s.rs2E       = 5'($urandom_range(0, 3));
    s.rdE        = 5'($urandom_range(0, 3));
    s.rdM        = 5'($urandom_range(0, 3));
    s.rdW        = 5'($urandom_range(0, 3));
    s.resultSrcE = 2'($urandom_range(0, 3));
    s.regWriteM  = 1'($urandom_range(0, 1));
    s.regWriteW  = 1'($urandom_range(0, 1));
    s.pcSrcE     = ($urandom_range(0, 4) == 0);
    s.memAccessM = ($urandom_range(0, 3) == 0);
    s.memReadyM  = ($urandom_range(0, 9) < 7);
    s.clearCount = ($urandom_range(0, 19) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    @(posedge clk); #1;

    // Reset held with hazards on the inputs: everything must stay quiet.
    for (int i = 0; i < 3; i++) applyCycle(randStim(), 1'b0);

    // Forwarding: memory priority, register zero, writeback path.
    s = quiet();
    s.rdM = 5; s.regWriteM = 1; s.rdW = 5; s.regWriteW = 1; s.rs1E = 5; s.rs2E = 5;
    applyCycle(s, 1'b1);
    s.rs1E = 0;
    applyCycle(s, 1'b1);
    s.rs1E = 5; s.rdM = 6;
    applyCycle(s, 1'b1);

    // Load-use stall held for several cycles.
    s = quiet();
    s.resultSrcE = 2'b01; s.rdE = 3; s.rs2D = 3;
    for (int i = 0; i < 3; i++) applyCycle(s, 1'b1);

    // Branch during a memory stall, then memory ready.
    s = quiet();
    s.pcSrcE = 1; s.memAccessM = 1; s.memReadyM = 0;
    applyCycle(s, 1'b1);
    s.memReadyM = 1;
    applyCycle(s, 1'b1);
    applyCycle(quiet(), 1'b1);

    // Load-use together with a taken branch.
    s = quiet();
    s.resultSrcE = 2'b01; s.rdE = 7; s.rs1D = 7; s.pcSrcE = 1;
    applyCycle(s, 1'b1);

    // Memory timeout, sticky error, asynchronous reset out of ERROR.
    s = quiet();
    s.memAccessM = 1; s.memReadyM = 0;
    for (int i = 0; i < 6; i++) applyCycle(s, 1'b1);
    s.memReadyM = 1;
    for (int i = 0; i < 2; i++) applyCycle(s, 1'b1);
    applyCycle(s, 1'b0);
    applyCycle(quiet(), 1'b0);

    // Reset mid-WAIT.
    s = quiet();
    s.memAccessM = 1; s.memReadyM = 0;
    for (int i = 0; i < 2; i++) applyCycle(s, 1'b1);
    applyCycle(s, 1'b0);

    // Counter saturation and clear overriding an active stall.
    s = quiet();
    s.clearCount = 1;
    applyCycle(s, 1'b1);
    s = quiet();
    s.resultSrcE = 2'b01; s.rdE = 2; s.rs1D = 2;
    for (int i = 0; i < 20; i++) applyCycle(s, 1'b1);
    s.clearCount = 1;
    applyCycle(s, 1'b1);
    s.clearCount = 0;
    applyCycle(s, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) applyCycle(randStim(), 1'b0);
      else                            applyCycle(randStim(), 1'b1);
    end

    @(negedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
